amiga_chipbus_slot_sched: RTL and testbench
===========================================

// Module: amiga_chipbus_slot_sched
// PURPOSE
//  Chip-bus slot scheduler. Shares chip RAM and custom registers between the 68000 and Agnus DMA
//  in fixed 4-clock memory slots. Drives the buffer-PAL control inputs: _RE, _RGAE, _DAE, _C1.
//  Also generates CPU _DTACK and the DMA grant. Sits between CPU address decode and the chip-bus buffer PAL.
// PARAMETERS
//  SLOT_CLKS   4  clocks per memory slot (phase counter 0..SLOT_CLKS-1); legal values 4 or 8
//  STARVE_MAX  3  consecutive CPU-denied DMA slots before the CPU is forced a slot (when BLTPRI=0)
//  C1_CLKS     2  clocks at slot start during which _C1 is low
// PORTS
//  CLK          in   1  chip-bus clock; all state changes on rising edge
//  _RESET       in   1  asynchronous active-low reset
//  _AS          in   1  CPU address strobe, active low (synchronised externally)
//  _PRW         in   1  CPU read/_write: 1=read, 0=write
//  CPU_RAM_SEL  in   1  decoded: current CPU cycle targets chip RAM
//  CPU_REG_SEL  in   1  decoded: current CPU cycle targets custom registers
//  DMA_REQ      in   1  Agnus requests the next slot
//  BLTPRI       in   1  1 = DMA never yields (blitter-nasty); 0 = starvation relief enabled
//  _RE          out  1  low for entire CPU chip-RAM slot
//  _RGAE        out  1  low for entire CPU register slot
//  _DAE         out  1  low for entire DMA slot
//  _C1          out  1  low for phases 0..C1_CLKS-1 of every slot, owned or idle
//  _DTACK       out  1  CPU data acknowledge, active low
//  DMA_ACK      out  1  one-clock high pulse at phase 0 of a granted DMA slot
//  PHASE        out  2  current slot phase (debug/visibility)
// BEHAVIOUR
//  - Reset (async, while _RESET=0): PHASE=0; owner=IDLE; starve=0; cpu_done=0.
//    Outputs on reset: _RE=_RGAE=_DAE=_DTACK=1, _C1=1, DMA_ACK=0. The first slot starts on the first edge after release.
//  - All outputs are registered. PHASE wraps SLOT_CLKS-1 -> 0 unconditionally.
//  - Arbitration happens on the edge where PHASE==SLOT_CLKS-1 and sets the owner of the next slot:
//      cpu_pend = !_AS && (CPU_RAM_SEL||CPU_REG_SEL) && !cpu_done
//      if DMA_REQ && !(cpu_pend && !BLTPRI && starve==STARVE_MAX) -> DMA
//      else if cpu_pend -> CPU_RAM if CPU_RAM_SEL else CPU_REG (RAM wins if both set)
//      else IDLE
//  - FSM states: IDLE, CPU_RAM, CPU_REG, DMA. The state is held for a whole slot and changes only at the wrap.
//  - Starve counter:
//      - increments (saturating at STARVE_MAX) when DMA is granted while cpu_pend=1;
//      - clears when the CPU is granted or cpu_pend=0.
//  - _DTACK:
//      - falls on the edge entering phase SLOT_CLKS-1 of a CPU slot, then sets cpu_done=1;
//      - stays low until _AS is sampled high, then rises on that edge and clears cpu_done.
//  - One CPU slot per _AS assertion. No new CPU grant while cpu_done=1.
//  - Latency: a CPU request sampled at the wrap edge gets _RE/_RGAE low on that edge. _DTACK goes low SLOT_CLKS-1 edges later.
//  - _AS rises mid-slot: the slot runs to completion (a RAM cycle cannot be aborted). _DTACK is not asserted.
//  - DMA_REQ drops mid-DMA slot: the slot completes. DMA_ACK has already pulsed.
//  - DMA_REQ and a CPU request arriving on the same sample edge: DMA wins unless the starvation rule applies.
//  - _PRW is not stored; it passes straight through to the buffer PAL. The scheduler only times the slot.
//  - Async reset mid-slot: every strobe deasserts immediately, with no partial completion.
// STRUCTURE
//  - Package amiga_chipbus_pkg holds:
//      - slot_owner_t enum {IDLE, CPU_RAM, CPU_REG, DMA};
//      - SLOT_CLKS_DEF and STARVE_MAX_DEF constants;
//      - the PHASE width.
//  - Sub-module amiga_chipbus_phase: free-running phase counter with a wrap strobe and a _C1 window decode.
//  - Arbitration, starve counter and _DTACK handshake live in the top level.
// TESTING
//  - Reset: hold _RESET=0 over 3 edges, release mid-slot.
//    Check all strobes high, DMA_ACK=0 and PHASE=0, then PHASE counts 0,1,2,3,0.
//  - CPU RAM read alone: _AS=0, CPU_RAM_SEL=1, DMA_REQ=0.
//    Check _RE low for 4 clocks and _DTACK low at phase 3. Raise _AS: _DTACK=1 next edge, and there is no second slot.
//  - DMA_REQ=1 held, BLTPRI=0, CPU RAM pending: slots go DMA,DMA,DMA,CPU_RAM. Starve reads 1,2,3 then 0.
//  - Same as the previous test with BLTPRI=1: DMA owns every slot for 20 slots, and _DTACK never falls.
//  - CPU_REG_SEL request with _AS released at phase 1: the slot completes with _RGAE low for 4 clocks. _DTACK stays high.
//  - Async reset asserted at phase 2 of a DMA slot: _DAE returns high with no clock edge.

Source files
------------

// File: rtl/amiga_chipbus_pkg.sv
// Shared types and constants for the chip-bus slot scheduler.
//   slot_owner_t : owner of the current 4/8-clock memory slot
//   *_DEF        : default scheduler parameters
//   PHASE_W      : width of the externally visible PHASE port
//   CNT_W        : width of the internal phase counter (covers SLOT_CLKS up to 8)
package amiga_chipbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RAM = 2'd1,
    CPU_REG = 2'd2,
    DMA     = 2'd3
  } slot_owner_t;

  localparam int unsigned SLOT_CLKS_DEF  = 4;
  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned C1_CLKS_DEF    = 2;

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CNT_W   = 3;

  function automatic logic is_cpu(slot_owner_t o);
    return (o == CPU_RAM) || (o == CPU_REG);
  endfunction

endpackage

// File: rtl/amiga_chipbus_slot_sched_if.sv
// Chip-bus scheduler signal bundle.
//   CPU/Agnus side -> scheduler : _AS, _PRW, CPU_RAM_SEL, CPU_REG_SEL, DMA_REQ, BLTPRI
//   scheduler -> buffer PAL/CPU : _RE, _RGAE, _DAE, _C1, _DTACK, DMA_ACK, PHASE
// master = the side driving requests, slave = the scheduler.
interface amiga_chipbus_slot_sched_if;
  import amiga_chipbus_pkg::*;

  logic               _AS;
  logic               _PRW;
  logic               CPU_RAM_SEL;
  logic               CPU_REG_SEL;
  logic               DMA_REQ;
  logic               BLTPRI;

  logic               _RE;
  logic               _RGAE;
  logic               _DAE;
  logic               _C1;
  logic               _DTACK;
  logic               DMA_ACK;
  logic [PHASE_W-1:0] PHASE;

  modport master (
    output _AS, _PRW, CPU_RAM_SEL, CPU_REG_SEL, DMA_REQ, BLTPRI,
    input  _RE, _RGAE, _DAE, _C1, _DTACK, DMA_ACK, PHASE
  );

  modport slave (
    input  _AS, _PRW, CPU_RAM_SEL, CPU_REG_SEL, DMA_REQ, BLTPRI,
    output _RE, _RGAE, _DAE, _C1, _DTACK, DMA_ACK, PHASE
  );

endinterface

// File: rtl/amiga_chipbus_phase.sv
// Free-running slot phase counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   phase_o       : current phase 0..SLOT_CLKS-1
//   wrap_o        : high during the last phase; the coming edge starts a new slot
//   c1_n_o        : registered _C1, low for phases 0..C1_CLKS-1
// Reset parks the counter in a pre-start state (phase 0, _C1 high); the
// first edge after release enters phase 0 of the first real slot.
module amiga_chipbus_phase
  import amiga_chipbus_pkg::*;
#(
  parameter int unsigned SLOT_CLKS = SLOT_CLKS_DEF,
  parameter int unsigned C1_CLKS   = C1_CLKS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] phase_o,
  output logic             wrap_o,
  output logic             c1_n_o
);

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(SLOT_CLKS - 1);
  localparam logic [CNT_W-1:0] C1_END  = CNT_W'(C1_CLKS);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic             started_q;
  logic             c1_n_q;

  assign wrap_o = started_q && (phase_q == PH_LAST);

  always_comb begin
    phase_d = phase_q;
    if (started_q) begin
      phase_d = wrap_o ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= '0;
      started_q <= 1'b0;
      c1_n_q    <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      started_q <= 1'b1;
      c1_n_q    <= !(phase_d < C1_END);
    end
  end

  assign phase_o = phase_q;
  assign c1_n_o  = c1_n_q;

endmodule

// File: rtl/amiga_chipbus_slot_sched.sv
// Chip-bus slot scheduler: shares chip RAM / custom registers between the
// 68000 and Agnus DMA in fixed SLOT_CLKS-clock slots.
//   CLK    : chip-bus clock
//   _RESET : asynchronous active-low reset
//   bus    : request inputs (_AS, _PRW, CPU_RAM_SEL, CPU_REG_SEL, DMA_REQ,
//            BLTPRI) and registered strobes (_RE, _RGAE, _DAE, _C1, _DTACK,
//            DMA_ACK, PHASE)
// The owner of the next slot is chosen on the wrap edge and held for the
// whole slot. _PRW goes straight to the buffer PAL; only timing is done here.
module amiga_chipbus_slot_sched
  import amiga_chipbus_pkg::*;
#(
  parameter int unsigned SLOT_CLKS  = SLOT_CLKS_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned C1_CLKS    = C1_CLKS_DEF
) (
  input logic                      CLK,
  input logic                      _RESET,
  amiga_chipbus_slot_sched_if.slave bus
);

  localparam int unsigned         STARVE_W    = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP  = STARVE_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]    PH_PRE_LAST = CNT_W'(SLOT_CLKS - 2);

  logic [CNT_W-1:0] phase;
  logic             wrap;
  logic             c1_n;

  amiga_chipbus_phase #(
    .SLOT_CLKS (SLOT_CLKS),
    .C1_CLKS   (C1_CLKS)
  ) u_phase (
    .clk_i   (CLK),
    .rst_ni  (_RESET),
    .phase_o (phase),
    .wrap_o  (wrap),
    .c1_n_o  (c1_n)
  );

  slot_owner_t         owner_q, arb_owner;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                cpu_done_q;
  logic                re_n_q, rgae_n_q, dae_n_q, dtack_n_q, dma_ack_q;
  logic                cpu_pend, starve_relief;

  always_comb begin
    cpu_pend      = !bus._AS && (bus.CPU_RAM_SEL || bus.CPU_REG_SEL) && !cpu_done_q;
    // Relief forces one CPU slot once DMA has beaten a waiting CPU STARVE_MAX times.
    starve_relief = cpu_pend && !bus.BLTPRI && (starve_q == STARVE_TOP);

    arb_owner = IDLE;
    if (bus.DMA_REQ && !starve_relief) begin
      arb_owner = DMA;
    end else if (cpu_pend) begin
      arb_owner = bus.CPU_RAM_SEL ? CPU_RAM : CPU_REG;
    end

    starve_d = '0;
    if ((arb_owner == DMA) && cpu_pend) begin
      starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      owner_q    <= IDLE;
      starve_q   <= '0;
      cpu_done_q <= 1'b0;
      re_n_q     <= 1'b1;
      rgae_n_q   <= 1'b1;
      dae_n_q    <= 1'b1;
      dtack_n_q  <= 1'b1;
      dma_ack_q  <= 1'b0;
    end else begin
      if (wrap) begin
        owner_q   <= arb_owner;
        starve_q  <= starve_d;
        re_n_q    <= (arb_owner != CPU_RAM);
        rgae_n_q  <= (arb_owner != CPU_REG);
        dae_n_q   <= (arb_owner != DMA);
        dma_ack_q <= (arb_owner == DMA);
      end else begin
        dma_ack_q <= 1'b0;
      end

      // _DTACK drops entering the last phase only if the CPU still holds _AS;
      // cpu_done then blocks a re-grant until _AS is seen high.
      if (!dtack_n_q) begin
        if (bus._AS) begin
          dtack_n_q  <= 1'b1;
          cpu_done_q <= 1'b0;
        end
      end else if (is_cpu(owner_q) && (phase == PH_PRE_LAST) && !bus._AS) begin
        dtack_n_q  <= 1'b0;
        cpu_done_q <= 1'b1;
      end
    end
  end

  assign bus._RE     = re_n_q;
  assign bus._RGAE   = rgae_n_q;
  assign bus._DAE    = dae_n_q;
  assign bus._C1     = c1_n;
  assign bus._DTACK  = dtack_n_q;
  assign bus.DMA_ACK = dma_ack_q;
  assign bus.PHASE   = phase[PHASE_W-1:0];

endmodule

// File: tb/tb_amiga_chipbus_slot_sched.sv
// Directed bench for amiga_chipbus_slot_sched. Expected output vectors
// {_RE,_RGAE,_DAE,_C1,_DTACK,DMA_ACK,PHASE[1:0]} are queued as each clock is
// driven and popped for comparison half a clock after the edge.
module tb_amiga_chipbus_slot_sched;

  logic CLK = 1'b0;
  logic _RESET;

  always #5 CLK = ~CLK;

  amiga_chipbus_slot_sched_if bus();

  amiga_chipbus_slot_sched #(
    .SLOT_CLKS  (4),
    .STARVE_MAX (3),
    .C1_CLKS    (2)
  ) dut (
    .CLK    (CLK),
    ._RESET (_RESET),
    .bus    (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [7:0] RST_V = 8'hF8;

  function automatic logic [7:0] obs();
    return {bus._RE, bus._RGAE, bus._DAE, bus._C1, bus._DTACK, bus.DMA_ACK, bus.PHASE};
  endfunction

  // _C1 follows the phase: low in phases 0 and 1 of every slot.
  function automatic logic [7:0] ev(logic re, logic rgae, logic dae, logic dtack,
                                    logic ack, int unsigned ph);
    logic c1;
    c1 = (ph < 2) ? 1'b0 : 1'b1;
    return {re, rgae, dae, c1, dtack, ack, 2'(ph)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s observed=%02h expected=%02h", tag, o, e);
    end
  endtask

  task automatic tick(input string tag, input logic [7:0] v);
    exp_t e;
    sb.push_back('{tag, v});
    @(posedge CLK);
    @(negedge CLK);
    e = sb.pop_front();
    chk(e.tag, obs(), e.v);
  endtask

  task automatic chk_starve(input string tag, input int unsigned s);
    chk(tag, 8'(dut.starve_q), 8'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    _RESET          = 1'b0;
    bus._AS         = 1'b1;
    bus._PRW        = 1'b1;
    bus.CPU_RAM_SEL = 1'b0;
    bus.CPU_REG_SEL = 1'b0;
    bus.DMA_REQ     = 1'b0;
    bus.BLTPRI      = 1'b0;

    // Reset held over 3 edges, released between edges.
    repeat (3) @(posedge CLK);
    #2 _RESET = 1'b1;
    @(negedge CLK);
    chk("reset_state", obs(), RST_V);
    for (int unsigned p = 0; p < 4; p++) tick("rst_count", ev(1, 1, 1, 1, 0, p));
    tick("rst_wrap", ev(1, 1, 1, 1, 0, 0));

    // CPU chip-RAM read, no DMA.
    bus._AS = 1'b0; bus.CPU_RAM_SEL = 1'b1; bus._PRW = 1'b1;
    for (int unsigned p = 1; p < 4; p++) tick("ram_wait", ev(1, 1, 1, 1, 0, p));
    for (int unsigned p = 0; p < 3; p++) tick("ram_slot", ev(0, 1, 1, 1, 0, p));
    tick("ram_dtack", ev(0, 1, 1, 0, 0, 3));
    tick("ram_no_regrant", ev(1, 1, 1, 0, 0, 0));
    bus._AS = 1'b1;
    tick("ram_dtack_rise", ev(1, 1, 1, 1, 0, 1));
    tick("ram_idle", ev(1, 1, 1, 1, 0, 2));
    tick("ram_idle", ev(1, 1, 1, 1, 0, 3));
    tick("ram_idle", ev(1, 1, 1, 1, 0, 0));

    // DMA held against a pending CPU with starvation relief enabled.
    bus.DMA_REQ = 1'b1; bus.BLTPRI = 1'b0; bus._AS = 1'b0;
    for (int unsigned p = 1; p < 4; p++) tick("stv_wait", ev(1, 1, 1, 1, 0, p));
    for (int unsigned s = 0; s < 3; s++) begin
      tick("stv_dma_ack", ev(1, 1, 0, 1, 1, 0));
      chk_starve("stv_count", s + 1);
      for (int unsigned p = 1; p < 4; p++) tick("stv_dma", ev(1, 1, 0, 1, 0, p));
    end
    tick("stv_cpu", ev(0, 1, 1, 1, 0, 0));
    chk_starve("stv_clear", 0);
    tick("stv_cpu", ev(0, 1, 1, 1, 0, 1));
    tick("stv_cpu", ev(0, 1, 1, 1, 0, 2));
    tick("stv_cpu_dtack", ev(0, 1, 1, 0, 0, 3));
    bus.DMA_REQ = 1'b0; bus._AS = 1'b1;
    tick("stv_end", ev(1, 1, 1, 1, 0, 0));
    for (int unsigned p = 1; p < 4; p++) tick("stv_idle", ev(1, 1, 1, 1, 0, p));

    // Blitter-nasty: DMA keeps every slot, CPU never acknowledged.
    bus.BLTPRI = 1'b1; bus.DMA_REQ = 1'b1; bus._AS = 1'b0;
    for (int unsigned s = 0; s < 20; s++) begin
      tick("nasty_ack", ev(1, 1, 0, 1, 1, 0));
      chk_starve("nasty_starve", (s + 1 > 3) ? 3 : s + 1);
      for (int unsigned p = 1; p < 4; p++) tick("nasty_dma", ev(1, 1, 0, 1, 0, p));
    end
    bus.BLTPRI = 1'b0; bus.DMA_REQ = 1'b0; bus._AS = 1'b1; bus.CPU_RAM_SEL = 1'b0;
    tick("nasty_end", ev(1, 1, 1, 1, 0, 0));
    chk_starve("nasty_clear", 0);
    for (int unsigned p = 1; p < 4; p++) tick("nasty_idle", ev(1, 1, 1, 1, 0, p));

    // Register access abandoned at phase 1: slot completes, no _DTACK.
    bus._AS = 1'b0; bus.CPU_REG_SEL = 1'b1;
    tick("reg_slot", ev(1, 0, 1, 1, 0, 0));
    tick("reg_slot", ev(1, 0, 1, 1, 0, 1));
    bus._AS = 1'b1;
    tick("reg_abort", ev(1, 0, 1, 1, 0, 2));
    tick("reg_no_dtack", ev(1, 0, 1, 1, 0, 3));
    tick("reg_end", ev(1, 1, 1, 1, 0, 0));
    tick("reg_idle", ev(1, 1, 1, 1, 0, 1));

    // Async reset in phase 2 of a DMA slot.
    bus.CPU_REG_SEL = 1'b0; bus.DMA_REQ = 1'b1;
    tick("ar_wait", ev(1, 1, 1, 1, 0, 2));
    tick("ar_wait", ev(1, 1, 1, 1, 0, 3));
    tick("ar_dma_ack", ev(1, 1, 0, 1, 1, 0));
    tick("ar_dma", ev(1, 1, 0, 1, 0, 1));
    tick("ar_dma", ev(1, 1, 0, 1, 0, 2));
    #2 _RESET = 1'b0;
    #1 chk("async_reset", obs(), RST_V);
    @(negedge CLK);
    chk("async_reset_hold", obs(), RST_V);
    _RESET = 1'b1;

    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
